// File: rtl/ch375_uart_fifo.sv
// Buffered CH375 9-bit serial link: TX/RX FIFOs, sticky error flags, maskable
// level interrupt and synchronised INT# status on the pCPU MMIO bus.

module ch375_fifo #(
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [8:0]    wdata,
   input  logic          pop,
   output logic [8:0]    rdata,
   output logic [AW:0]   level,
   output logic          empty,
   output logic          full,
   output logic          ovf
);
   localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

   logic [8:0]    mem [0:(1 << AW) - 1];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          pop_ok;
   logic          push_ok;

   assign empty   = (level == '0);
   assign full    = (level == DEPTH);
   assign pop_ok  = pop && !empty;
   // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
   assign push_ok = push && (!full || pop_ok);
   assign ovf     = push && !push_ok;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end
endmodule

module ch375_uart_fifo #(
   parameter int CLOCK_FREQ = 0,
   parameter int BAUD_RATE  = 0,
   parameter int FIFO_AW    = 4,
   parameter int NINTH_BIT  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  a,
   input  logic [31:0] d,
   input  logic        we,
   output logic [31:0] spo,
   output logic        irq,
   output logic        ser_tx,
   input  logic        ser_rx,
   input  logic        dev_nint
);
   localparam int DIV_RAW = (BAUD_RATE > 0) ? CLOCK_FREQ / (16 * BAUD_RATE) : 1;
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

   typedef enum logic [2:0] {TS_IDLE, TS_START, TS_DATA, TS_CMD, TS_STOP} tx_state_t;
   typedef enum logic [1:0] {RS_START, RS_DATA, RS_CMD, RS_STOP} rx_state_t;

   logic [DIV_W-1:0] div_cnt;
   logic [3:0]       tick16;
   logic             rx_tick;
   logic             tx_tick;

   logic rx_sync_p0, rx_sync_p1;
   logic nint_sync_p0, nint_sync_p1;
   logic rx_sync, nint_sync;

   logic             tx_push, tx_pop, tx_empty, tx_full, tx_ovf_set;
   logic [8:0]       tx_wdata, tx_rdata;
   logic [FIFO_AW:0] tx_level;
   tx_state_t        tx_state;
   logic [7:0]       tx_sh;
   logic             tx_cmd;
   logic [2:0]       tx_bit;

   logic             rx_push, rx_pop, rx_empty, rx_full, rx_ovf_set;
   logic [8:0]       rx_wdata, rx_rdata;
   logic [FIFO_AW:0] rx_level;
   rx_state_t        rx_state;
   logic             rx_seen;
   logic [3:0]       rx_cnt;
   logic [2:0]       rx_bit;
   logic [7:0]       rx_sh;
   logic             rx_cmd;
   logic             rx_stop_smp;
   logic             frame_set;

   logic       tx_ovf, rx_frame_err, rx_ovf;
   logic [2:0] err_clr;
   logic [1:0] ie;
   logic       unused_bits;

   assign unused_bits = ^d[23:0];

   // Baud generator: 16x oversample tick, bit tick on every 16th
   assign rx_tick = (div_cnt == DIV_W'(DIV - 1));
   assign tx_tick = rx_tick && (tick16 == 4'd15);

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt <= '0;
         tick16  <= '0;
      end else begin
         div_cnt <= rx_tick ? '0 : div_cnt + 1'b1;
         if (rx_tick) tick16 <= tick16 + 1'b1;
      end
   end

   // Input synchronisers
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_sync_p0   <= 1'b1;
         rx_sync_p1   <= 1'b1;
         nint_sync_p0 <= 1'b1;
         nint_sync_p1 <= 1'b1;
      end else begin
         rx_sync_p0   <= ser_rx;
         rx_sync_p1   <= rx_sync_p0;
         nint_sync_p0 <= dev_nint;
         nint_sync_p1 <= nint_sync_p0;
      end
   end

   assign rx_sync   = rx_sync_p1;
   assign nint_sync = nint_sync_p1;

   assign tx_push  = we && ((a == 3'd0) || (a == 3'd2));
   assign tx_wdata = {(a == 3'd0), d[31:24]};
   assign tx_pop   = (tx_state == TS_IDLE) && !tx_empty;
   assign rx_pop   = we && (a == 3'd1);
   assign err_clr  = (we && (a == 3'd6)) ? d[26:24] : 3'b000;

   ch375_fifo #(.AW(FIFO_AW)) u_tx_fifo (
      .clk(clk), .rst(rst), .push(tx_push), .wdata(tx_wdata), .pop(tx_pop),
      .rdata(tx_rdata), .level(tx_level), .empty(tx_empty), .full(tx_full),
      .ovf(tx_ovf_set)
   );

   ch375_fifo #(.AW(FIFO_AW)) u_rx_fifo (
      .clk(clk), .rst(rst), .push(rx_push), .wdata(rx_wdata), .pop(rx_pop),
      .rdata(rx_rdata), .level(rx_level), .empty(rx_empty), .full(rx_full),
      .ovf(rx_ovf_set)
   );

   // Transmitter: each state drives its bit on a tx_tick and holds it a full bit
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state <= TS_IDLE;
         ser_tx   <= 1'b1;
         tx_bit   <= '0;
      end else begin
         unique case (tx_state)
            TS_IDLE: if (!tx_empty) tx_state <= TS_START;
            TS_START: if (tx_tick) begin
               ser_tx   <= 1'b0;
               tx_bit   <= '0;
               tx_state <= TS_DATA;
            end
            TS_DATA: if (tx_tick) begin
               ser_tx <= tx_sh[0];
               tx_bit <= tx_bit + 1'b1;
               if (tx_bit == 3'd7) tx_state <= (NINTH_BIT != 0) ? TS_CMD : TS_STOP;
            end
            TS_CMD: if (tx_tick) begin
               ser_tx   <= tx_cmd;
               tx_state <= TS_STOP;
            end
            TS_STOP: if (tx_tick) begin
               ser_tx   <= 1'b1;
               tx_state <= TS_IDLE;
            end
            default: tx_state <= TS_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (tx_pop)                                {tx_cmd, tx_sh} <= tx_rdata;
      else if ((tx_state == TS_DATA) && tx_tick) tx_sh <= {1'b0, tx_sh[7:1]};
   end

   // Receiver: after the start re-check the counter is phased so cnt==8 is mid-bit
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state <= RS_START;
         rx_seen  <= 1'b0;
         rx_cnt   <= '0;
         rx_bit   <= '0;
      end else if (rx_tick) begin
         unique case (rx_state)
            RS_START: begin
               if (!rx_seen) begin
                  if (!rx_sync) begin
                     rx_seen <= 1'b1;
                     rx_cnt  <= '0;
                  end
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
                  if (rx_cnt == 4'd7) begin
                     rx_seen <= 1'b0;
                     if (!rx_sync) begin
                        rx_state <= RS_DATA;
                        rx_cnt   <= 4'd9;
                        rx_bit   <= '0;
                     end
                  end
               end
            end
            RS_DATA: begin
               rx_cnt <= rx_cnt + 1'b1;
               if (rx_cnt == 4'd8) begin
                  rx_bit <= rx_bit + 1'b1;
                  if (rx_bit == 3'd7) rx_state <= (NINTH_BIT != 0) ? RS_CMD : RS_STOP;
               end
            end
            RS_CMD: begin
               rx_cnt <= rx_cnt + 1'b1;
               if (rx_cnt == 4'd8) rx_state <= RS_STOP;
            end
            RS_STOP: begin
               rx_cnt <= rx_cnt + 1'b1;
               if (rx_cnt == 4'd8) rx_state <= RS_START;
            end
            default: rx_state <= RS_START;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rx_tick && (rx_cnt == 4'd8)) begin
         if (rx_state == RS_DATA) rx_sh  <= {rx_sync, rx_sh[7:1]};
         if (rx_state == RS_CMD)  rx_cmd <= rx_sync;
      end
   end

   assign rx_stop_smp = rx_tick && (rx_state == RS_STOP) && (rx_cnt == 4'd8);
   assign rx_push     = rx_stop_smp && rx_sync;
   assign frame_set   = rx_stop_smp && !rx_sync;
   assign rx_wdata    = {((NINTH_BIT != 0) ? rx_cmd : 1'b0), rx_sh};

   // Sticky flags: a set event in the same cycle as a clear wins
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_ovf       <= 1'b0;
         rx_frame_err <= 1'b0;
         rx_ovf       <= 1'b0;
         ie           <= 2'b00;
         irq          <= 1'b0;
      end else begin
         tx_ovf       <= (tx_ovf & ~err_clr[2]) | tx_ovf_set;
         rx_frame_err <= (rx_frame_err & ~err_clr[1]) | frame_set;
         rx_ovf       <= (rx_ovf & ~err_clr[0]) | rx_ovf_set;
         if (we && (a == 3'd7)) ie <= d[25:24];
         irq <= (ie[0] & ~rx_empty) | (ie[1] & ~nint_sync);
      end
   end

   always_comb begin
      spo = '0;
      case (a)
         3'd0: if (!rx_empty) spo = {rx_rdata[7:0], rx_rdata[8], 23'b0};
         3'd1: spo[24] = !rx_empty;
         3'd2: spo[24] = tx_empty && (tx_state == TS_IDLE);
         3'd3: spo[24] = nint_sync;
         3'd4: spo[31:24] = 8'(rx_level);
         3'd5: spo[31:24] = 8'(tx_level);
         3'd6: spo[26:24] = {tx_ovf, rx_frame_err, rx_ovf};
         3'd7: spo[25:24] = ie;
         default: spo = '0;
      endcase
   end
endmodule

// File: tb/tb_ch375_uart_fifo.sv
// Directed bench for ch375_uart_fifo at 16 MHz / 1 Mbaud (one bit = 16 clk).

module tb_ch375_uart_fifo;
   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  a;
   logic [31:0] d;
   logic        we;
   logic [31:0] spo;
   logic        irq;
   logic        ser_tx;
   logic        ser_rx;
   logic        dev_nint;

   int checks   = 0;
   int failures = 0;

   typedef struct { logic [2:0] a; logic [31:0] exp; } rd_vec_t;
   typedef struct { logic [2:0] a; logic [7:0] b; logic [10:0] frame; } tx_vec_t;
   typedef struct { logic [7:0] b; logic c; logic [31:0] exp0; } rx_vec_t;

   rd_vec_t rd_tab [8];
   tx_vec_t tx_tab [4];
   rx_vec_t rx_tab [4];

   ch375_uart_fifo #(
      .CLOCK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .FIFO_AW(4), .NINTH_BIT(1)
   ) dut (
      .clk(clk), .rst(rst), .a(a), .d(d), .we(we), .spo(spo), .irq(irq),
      .ser_tx(ser_tx), .ser_rx(ser_rx), .dev_nint(dev_nint)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h", nm, act, exp);
      end
   endtask

   task automatic chk_rd(input string nm, input logic [2:0] ra, input logic [31:0] exp);
      a = ra;
      #1;
      chk(nm, spo, exp);
   endtask

   task automatic bus_wr(input logic [2:0] ra, input logic [31:0] rd);
      @(negedge clk);
      a  = ra;
      d  = rd;
      we = 1'b1;
      @(negedge clk);
      we = 1'b0;
      d  = '0;
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Checks 11 bits at mid-bit; with wait_edge=0 it expects the start bit
   // to begin right after the previous frame's stop bit.
   task automatic chk_tx_frame(input string nm, input logic [10:0] fr, input bit wait_edge);
      bit found = 0;
      if (wait_edge) begin
         for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (ser_tx == 1'b0) begin
               found = 1;
               break;
            end
         end
         if (!found) begin
            checks++;
            failures++;
            $display("FAIL %s_start: no start bit within 4000 clk", nm);
            return;
         end
         wait_clks(8);
      end else begin
         wait_clks(16);
      end
      for (int j = 0; j < 11; j++) begin
         chk($sformatf("%s_bit%0d", nm, j), {31'b0, ser_tx}, {31'b0, fr[j]});
         if (j < 10) wait_clks(16);
      end
   endtask

   // Drives one frame; pop_at >= 0 issues a bus pop on that clock of the frame.
   task automatic send_rx(input logic [7:0] b, input logic c, input logic stop, input int pop_at);
      logic [10:0] bits;
      bits = {stop, c, b, 1'b0};
      for (int k = 0; k < 176; k++) begin
         @(negedge clk);
         ser_rx = bits[k / 16];
         if (k == pop_at) begin
            a  = 3'd1;
            d  = '0;
            we = 1'b1;
         end else begin
            we = 1'b0;
         end
      end
      @(negedge clk);
      ser_rx = 1'b1;
      we     = 1'b0;
   endtask

   initial begin
      rst = 1'b1; a = '0; d = '0; we = 1'b0; ser_rx = 1'b1; dev_nint = 1'b1;
      rd_tab[0] = '{a: 3'd0, exp: 32'h0000_0000};
      rd_tab[1] = '{a: 3'd1, exp: 32'h0000_0000};
      rd_tab[2] = '{a: 3'd2, exp: 32'h0100_0000};
      rd_tab[3] = '{a: 3'd3, exp: 32'h0100_0000};
      rd_tab[4] = '{a: 3'd4, exp: 32'h0000_0000};
      rd_tab[5] = '{a: 3'd5, exp: 32'h0000_0000};
      rd_tab[6] = '{a: 3'd6, exp: 32'h0000_0000};
      rd_tab[7] = '{a: 3'd7, exp: 32'h0000_0000};
      tx_tab[0] = '{a: 3'd2, b: 8'hA5, frame: 11'b10101001010};
      tx_tab[1] = '{a: 3'd0, b: 8'hFF, frame: 11'b11111111110};
      tx_tab[2] = '{a: 3'd2, b: 8'h00, frame: 11'b10000000000};
      tx_tab[3] = '{a: 3'd0, b: 8'h3C, frame: 11'b11001111000};
      rx_tab[0] = '{b: 8'h3C, c: 1'b1, exp0: 32'h3C80_0000};
      rx_tab[1] = '{b: 8'hA5, c: 1'b0, exp0: 32'hA500_0000};
      rx_tab[2] = '{b: 8'h00, c: 1'b1, exp0: 32'h0080_0000};
      rx_tab[3] = '{b: 8'hFF, c: 1'b0, exp0: 32'hFF00_0000};

      wait_clks(4);
      rst = 1'b0;
      wait_clks(2);

      // Reset state
      chk("rst_ser_tx", {31'b0, ser_tx}, 32'd1);
      chk("rst_irq", {31'b0, irq}, 32'd0);
      for (int i = 0; i < 8; i++)
         chk_rd($sformatf("rst_reg%0d", rd_tab[i].a), rd_tab[i].a, rd_tab[i].exp);

      // Single TX frames
      for (int i = 0; i < 4; i++) begin
         bus_wr(tx_tab[i].a, {tx_tab[i].b, 24'b0});
         chk_tx_frame($sformatf("tx%0d", i), tx_tab[i].frame, 1'b1);
         wait_clks(16);
         chk_rd($sformatf("tx%0d_idle", i), 3'd2, 32'h0100_0000);
      end

      // Back-to-back frames, no idle gap
      bus_wr(3'd0, 32'h5700_0000);
      bus_wr(3'd2, 32'h0100_0000);
      chk_tx_frame("b2b_first", 11'b11010101110, 1'b1);
      chk_tx_frame("b2b_second", 11'b10000000010, 1'b0);
      wait_clks(16);

      // INT# status and its interrupt enable
      dev_nint = 1'b0;
      wait_clks(4);
      chk_rd("nint_low", 3'd3, 32'h0000_0000);
      bus_wr(3'd7, 32'h0200_0000);
      wait_clks(2);
      chk("nint_irq_on", {31'b0, irq}, 32'd1);
      dev_nint = 1'b1;
      wait_clks(4);
      chk("nint_irq_off", {31'b0, irq}, 32'd0);
      chk_rd("nint_high", 3'd3, 32'h0100_0000);
      bus_wr(3'd7, 32'h0100_0000);
      chk_rd("ie_read", 3'd7, 32'h0100_0000);

      // RX frames with interrupt
      for (int i = 0; i < 4; i++) begin
         send_rx(rx_tab[i].b, rx_tab[i].c, 1'b1, -1);
         wait_clks(4);
         chk($sformatf("rx%0d_irq", i), {31'b0, irq}, 32'd1);
         chk_rd($sformatf("rx%0d_data", i), 3'd0, rx_tab[i].exp0);
         chk_rd($sformatf("rx%0d_nonempty", i), 3'd1, 32'h0100_0000);
         chk_rd($sformatf("rx%0d_level", i), 3'd4, 32'h0100_0000);
         @(negedge clk);
         a = 3'd1; d = '0; we = 1'b1;
         @(negedge clk);
         we = 1'b0;
         chk($sformatf("rx%0d_irq_hold", i), {31'b0, irq}, 32'd1);
         @(negedge clk);
         chk($sformatf("rx%0d_irq_fall", i), {31'b0, irq}, 32'd0);
      end

      // Stop bit low
      send_rx(8'h55, 1'b0, 1'b0, -1);
      wait_clks(30);
      chk_rd("ferr_flag", 3'd6, 32'h0200_0000);
      chk_rd("ferr_nopush", 3'd1, 32'h0000_0000);
      bus_wr(3'd6, 32'h0200_0000);
      chk_rd("ferr_clear", 3'd6, 32'h0000_0000);

      // Short glitch is a false start
      @(negedge clk);
      ser_rx = 1'b0;
      wait_clks(4);
      ser_rx = 1'b1;
      wait_clks(200);
      chk_rd("glitch_nopush", 3'd1, 32'h0000_0000);
      chk_rd("glitch_noerr", 3'd6, 32'h0000_0000);

      // RX full: overrun, then a pop in the stop-sample cycle
      for (int i = 0; i < 16; i++) send_rx(8'h10 + 8'(i), i[0], 1'b1, -1);
      chk_rd("fill_level", 3'd4, 32'h1000_0000);
      send_rx(8'hEE, 1'b1, 1'b1, -1);
      wait_clks(4);
      chk_rd("ovf_flag", 3'd6, 32'h0100_0000);
      chk_rd("ovf_level", 3'd4, 32'h1000_0000);
      chk_rd("ovf_head", 3'd0, 32'h1000_0000);
      bus_wr(3'd6, 32'h0100_0000);
      chk_rd("ovf_clear", 3'd6, 32'h0000_0000);
      send_rx(8'h77, 1'b1, 1'b1, 170);
      wait_clks(4);
      chk_rd("popsame_noovf", 3'd6, 32'h0000_0000);
      chk_rd("popsame_level", 3'd4, 32'h1000_0000);
      chk_rd("popsame_head", 3'd0, 32'h1180_0000);
      for (int i = 0; i < 15; i++) bus_wr(3'd1, 32'h0);
      chk_rd("popsame_tail", 3'd0, 32'h7780_0000);
      chk_rd("popsame_left", 3'd4, 32'h0100_0000);

      // TX overflow with the transmitter busy on the first byte
      bus_wr(3'd2, 32'h8100_0000);
      wait_clks(3);
      for (int i = 0; i < 17; i++) bus_wr(3'd2, {8'(i), 24'b0});
      chk_rd("txovf_level", 3'd5, 32'h1000_0000);
      chk_rd("txovf_flag", 3'd6, 32'h0400_0000);
      bus_wr(3'd6, 32'h0400_0000);
      chk_rd("txovf_clear", 3'd6, 32'h0000_0000);
      chk_rd("txovf_level2", 3'd5, 32'h1000_0000);

      // Reset in the middle of a TX frame
      begin
         bit low = 0;
         for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (ser_tx == 1'b0) begin
               low = 1;
               break;
            end
         end
         chk("midrst_low_seen", {31'b0, low}, 32'd1);
      end
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_ser_tx", {31'b0, ser_tx}, 32'd1);
      rst = 1'b0;
      chk_rd("midrst_rx_level", 3'd4, 32'h0000_0000);
      chk_rd("midrst_tx_level", 3'd5, 32'h0000_0000);
      chk_rd("midrst_tx_idle", 3'd2, 32'h0100_0000);
      chk("midrst_irq", {31'b0, irq}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
